// File: rtl/mem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package mem_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE,
    MEM_BUSY
  } mem_state_e;

  localparam int unsigned ADDR_LSB = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word storage with per-byte-lane write enables and an asynchronous read port.
module mem_byte_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic                  clk,
  input  logic [DATA_W/8-1:0]   lane_we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (lane_we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory: base-address window decode, byte enables and programmable
// wait states with a ready handshake for the pipeline stall logic.
module data_memory_ws
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [31:0]           address,
  input  logic [DATA_W-1:0]     dataToWrite,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     result,
  output logic                  ready,
  output logic                  addr_err
);

  localparam int unsigned Lanes    = DATA_W / 8;
  localparam int unsigned IdxW     = idx_width(DEPTH_WORDS);
  localparam logic [31:0] Base     = 32'(BASE_ADDR);
  localparam logic [31:0] WinBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [Lanes-1:0]    be_q, be_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                addr_err_q, addr_err_d;

  logic [31:0]         op_addr, offset;
  logic [DATA_W-1:0]   op_data, rd_data;
  logic [Lanes-1:0]    op_be, lane_we;
  logic                op_wr, in_range, perform;
  logic [IdxW-1:0]     word_idx;

  // In IDLE the operation comes straight from the inputs (zero-wait path);
  // in BUSY it comes from the copy latched at accept.
  always_comb begin
    if (state_q == MEM_IDLE) begin
      op_addr = address;
      op_data = dataToWrite;
      op_be   = byte_en;
      op_wr   = mem_w_en;
    end else begin
      op_addr = addr_q;
      op_data = data_q;
      op_be   = be_q;
      op_wr   = wr_q;
    end
  end

  assign offset   = op_addr - Base;
  assign in_range = (op_addr >= Base) && (offset < WinBytes);
  assign word_idx = offset[ADDR_LSB +: IdxW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    wr_d       = wr_q;
    result_d   = result_q;
    addr_err_d = 1'b0;
    perform    = 1'b0;
    lane_we    = '0;

    unique case (state_q)
      MEM_IDLE: begin
        if (mem_r_en || mem_w_en) begin
          addr_d = address;
          data_d = dataToWrite;
          be_d   = byte_en;
          wr_d   = mem_w_en;
          if (WAIT_CYCLES == 0) begin
            perform = 1'b1;
          end else begin
            state_d = MEM_BUSY;
            cnt_d   = WaitLoad;
          end
        end
      end
      MEM_BUSY: begin
        if (cnt_q == 4'd0) begin
          perform = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase

    if (perform) begin
      addr_err_d = !in_range;
      if (op_wr) begin
        lane_we = in_range ? op_be : '0;
      end else begin
        result_d = in_range ? rd_data : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      result_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      wr_q       <= wr_d;
      result_q   <= result_d;
      addr_err_q <= addr_err_d;
    end
  end

  mem_byte_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) u_array (
    .clk     (clk),
    .lane_we (lane_we),
    .addr    (word_idx),
    .wdata   (op_data),
    .rdata   (rd_data)
  );

  assign result   = result_q;
  assign addr_err = addr_err_q;
  assign ready    = (state_q == MEM_IDLE);

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Parametrised, word-organised data memory for the ARM pipeline MEM stage.
- Maps a configurable base address window onto DEPTH_WORDS 32-bit words.
- Supports per-byte write enables and a programmable wait-state count, so the pipeline can be exercised against slow memory.
- Drives a ready handshake that the hazard/stall unit uses to freeze the pipeline while an access is in flight.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH_WORDS, 64, number of words stored; power of two.
- BASE_ADDR, 1024, byte address of word 0.
- WAIT_CYCLES, 0, stall cycles inserted per accepted access (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- mem_r_en  in  1  read request
- mem_w_en  in  1  write request
- address  in  32  byte address
- dataToWrite  in  DATA_W  write data
- byte_en  in  DATA_W/8  write byte-lane mask; bit i covers dataToWrite[8i+7:8i]
- result  out  DATA_W  read data; holds last completed read
- ready  out  1  high = idle and able to accept; low = access in flight, pipeline must stall
- addr_err  out  1  one-cycle pulse when an out-of-window access completes

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, wait counter=0, result=0, ready=1, addr_err=0. Memory array contents are not reset. Reset asserted mid-access aborts the access; no partial write occurs.
- Address decode: offset = address - BASE_ADDR (32-bit wrap). word index = offset[2+log2(DEPTH_WORDS)-1:2]. address[1:0] is ignored (word-aligned access). in_range = address >= BASE_ADDR and offset < DEPTH_WORDS*4.
- Byte order: little-endian. Byte lane i of a word is bits [8i+7:8i].
- Accept: a request is accepted on a rising edge where state=IDLE and (mem_r_en or mem_w_en). Address, data, byte_en and op are latched at that edge; inputs may change afterwards.
- Simultaneous mem_r_en and mem_w_en: treated as a write. result is unchanged.
- FSM:
  - IDLE: ready=1. If WAIT_CYCLES=0, an accepted access performs at the accept edge and the state stays IDLE. Otherwise, go to BUSY with counter=WAIT_CYCLES-1.
  - BUSY: ready=0. Counter decrements each cycle. On the edge where counter=0, the access performs and the state returns to IDLE. ready therefore stays low for exactly WAIT_CYCLES cycles after accept.
- Perform write: for each i with byte_en[i]=1 and in_range, the lane is written. Lanes with byte_en[i]=0 keep their old value.
- Perform read: if in_range, result <= stored word; else result <= 0.
- Out-of-range access: no array write. addr_err=1 for the single cycle after the perform edge. ready behaves normally.
- ready is a registered-state decode (no combinational path from request inputs).
- Back-to-back requests: with WAIT_CYCLES=0, one access per cycle. With WAIT_CYCLES=N, at most one per N+1 cycles. A request held high through BUSY is not re-accepted until ready is 1 again; the next accept occurs on the first edge with state=IDLE.

Decomposition:
- Shared package mem_pkg holds:
  - FSM state enum (MEM_IDLE, MEM_BUSY);
  - localparam ADDR_LSB=2;
  - function for the word-index width (clog2 of DEPTH_WORDS).
- One natural sub-module, mem_byte_array: DEPTH_WORDS x DATA_W storage with a per-lane write enable and an asynchronous read port.
- The top level holds the FSM, wait counter, decode, result register and addr_err.

Test Plan:
- Reset mid-BUSY: WAIT_CYCLES=3, write 0xDEADBEEF to 1024, assert rst on cycle 2 after accept -> ready=1, result=0, addr_err=0 immediately. A subsequent read of 1024 returns the pre-test contents, not 0xDEADBEEF.
- Zero-wait write/read: WAIT_CYCLES=0, write 0x11223344 to 1028 with byte_en=0xF, read 1028 next cycle -> result=0x11223344 one edge after read accept; ready stays 1 throughout.
- Byte enables: word at 1032 = 0xAABBCCDD; write 0x00000099 with byte_en=0x1, then 0x77000000 with byte_en=0x8 -> read returns 0x77BBCC99.
- Wait states: WAIT_CYCLES=3, read 1024 -> ready low for exactly 3 cycles; result updates on the edge ready returns to 1. Request held high is not double-accepted.
- Out of range: read 1020 and write 1024+4*DEPTH_WORDS -> result=0 after the read, one-cycle addr_err pulse per access, no array word modified (full readback check).
- Simultaneous r/w plus misalignment: mem_r_en=mem_w_en=1, address 1027, data 0xCAFEF00D -> word at 1024 becomes 0xCAFEF00D; result retains its prior value.
